// File: rtl/timer_arbiter.sv
// Lends one interval timer to NUM_REQ requesters in round-robin order. It aborts an
// interval when the owner withdraws its request or when the timer overruns (watchdog).
module timer_arbiter #(
    parameter int NUM_REQ   = 3,
    parameter int CNT_W     = 18,
    parameter int WD_MARGIN = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [NUM_REQ-1:0]       req_i,
    input  logic [NUM_REQ*CNT_W-1:0] req_count_i,
    output logic [NUM_REQ-1:0]       grant_o,
    output logic [NUM_REQ-1:0]       done_o,
    output logic                     err_o,
    output logic                     busy_o,
    output logic [CNT_W-1:0]         tmr_count_o,
    output logic                     tmr_start_o,
    output logic                     tmr_abort_o,
    input  logic                     tmr_done_i
);

    localparam int                IDX_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX    = IDX_W'(NUM_REQ - 1);
    localparam logic [CNT_W:0]    WD_MARGIN_W = (CNT_W+1)'(WD_MARGIN);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    function automatic logic [IDX_W-1:0] rot_idx(input logic [IDX_W-1:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        sum = (sum >= NUM_REQ) ? (sum - NUM_REQ) : sum;
        return IDX_W'(sum);
    endfunction

    function automatic logic [IDX_W-1:0] inc_wrap(input logic [IDX_W-1:0] idx);
        return (idx == LAST_IDX) ? {IDX_W{1'b0}} : (idx + {{(IDX_W-1){1'b0}}, 1'b1});
    endfunction

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     ptr_q, ptr_d;
    logic [IDX_W-1:0]     owner_q, owner_d;
    logic [CNT_W:0]       wd_q, wd_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [NUM_REQ-1:0]   done_q, done_d;
    logic                 err_q, err_d;
    logic                 busy_q, busy_d;
    logic [CNT_W-1:0]     tmr_count_q, tmr_count_d;
    logic                 tmr_start_q, tmr_start_d;
    logic                 tmr_abort_q, tmr_abort_d;

    logic [IDX_W-1:0]     sel_idx_s;
    logic [NUM_REQ-1:0]   sel_onehot_s;
    logic [CNT_W-1:0]     sel_cnt_s;
    logic                 sel_found_s;
    logic                 owner_req_s;
    logic [CNT_W:0]       wd_limit_s;

    // Round-robin pick: walk offsets from the far end so the lowest offset from ptr wins.
    always_comb begin
        sel_idx_s   = {IDX_W{1'b0}};
        sel_found_s = |req_i;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            sel_idx_s = req_i[rot_idx(ptr_q, i)] ? rot_idx(ptr_q, i) : sel_idx_s;
        end
        sel_onehot_s = {{(NUM_REQ-1){1'b0}}, 1'b1} << sel_idx_s;
    end

    // Mux out the winner's terminal count.
    always_comb begin
        sel_cnt_s = {CNT_W{1'b0}};
        for (int i = 0; i < NUM_REQ; i++) begin
            sel_cnt_s = sel_cnt_s | (req_count_i[i*CNT_W +: CNT_W] & {CNT_W{sel_onehot_s[i]}});
        end
    end

    assign owner_req_s = |(req_i & grant_q);
    assign wd_limit_s  = {1'b0, tmr_count_q} + WD_MARGIN_W;

    // Next-state and registered-output logic of the arbitration FSM.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        owner_d     = owner_q;
        wd_d        = wd_q;
        grant_d     = grant_q;
        tmr_count_d = tmr_count_q;
        done_d      = {NUM_REQ{1'b0}};
        err_d       = 1'b0;
        tmr_start_d = 1'b0;
        tmr_abort_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (sel_found_s) begin
                    grant_d     = sel_onehot_s;
                    owner_d     = sel_idx_s;
                    tmr_count_d = sel_cnt_s;
                    state_d     = (sel_cnt_s == {CNT_W{1'b0}}) ? S_DONE : S_START;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_START: begin
                tmr_start_d = 1'b1;
                wd_d        = {(CNT_W+1){1'b0}};
                state_d     = S_WAIT;
            end
            S_WAIT: begin
                if (!owner_req_s) begin
                    tmr_abort_d = 1'b1;
                    grant_d     = {NUM_REQ{1'b0}};
                    ptr_d       = inc_wrap(owner_q);
                    state_d     = S_IDLE;
                end else if (tmr_done_i) begin
                    state_d = S_DONE;
                end else if (wd_q == wd_limit_s) begin
                    tmr_abort_d = 1'b1;
                    err_d       = 1'b1;
                    state_d     = S_DONE;
                end else begin
                    wd_d = wd_q + {{CNT_W{1'b0}}, 1'b1};
                end
            end
            S_DONE: begin
                done_d  = grant_q;
                grant_d = {NUM_REQ{1'b0}};
                ptr_d   = inc_wrap(owner_q);
                state_d = S_IDLE;
            end
            default: begin
                grant_d = {NUM_REQ{1'b0}};
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            ptr_q       <= {IDX_W{1'b0}};
            owner_q     <= {IDX_W{1'b0}};
            wd_q        <= {(CNT_W+1){1'b0}};
            grant_q     <= {NUM_REQ{1'b0}};
            done_q      <= {NUM_REQ{1'b0}};
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
            tmr_count_q <= {CNT_W{1'b0}};
            tmr_start_q <= 1'b0;
            tmr_abort_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            owner_q     <= owner_d;
            wd_q        <= wd_d;
            grant_q     <= grant_d;
            done_q      <= done_d;
            err_q       <= err_d;
            busy_q      <= busy_d;
            tmr_count_q <= tmr_count_d;
            tmr_start_q <= tmr_start_d;
            tmr_abort_q <= tmr_abort_d;
        end
    end

    assign grant_o     = grant_q;
    assign done_o      = done_q;
    assign err_o       = err_q;
    assign busy_o      = busy_q;
    assign tmr_count_o = tmr_count_q;
    assign tmr_start_o = tmr_start_q;
    assign tmr_abort_o = tmr_abort_q;

endmodule

// File: tb/tb_timer_arbiter.sv
// Scoreboard bench for timer_arbiter: expected output events are queued with their
// cycle numbers and matched against events logged by a negedge monitor.
module tb_timer_arbiter;

    localparam int CW = 18;
    localparam int K_GRANT = 0, K_START = 1, K_ABORT = 2, K_ERR = 3, K_DONE = 4;

    typedef struct {
        int kind;
        int val;
        int cyc;
    } ev_t;

    logic            clk_i = 1'b0;
    logic            rst_ni = 1'b0;
    logic [2:0]      req_i = 3'd0;
    logic [3*CW-1:0] req_count_i = {(3*CW){1'b0}};
    logic [2:0]      grant_o, done_o;
    logic            err_o, busy_o, tmr_start_o, tmr_abort_o;
    logic [CW-1:0]   tmr_count_o;
    logic            tmr_done_i;
    logic            model_done = 1'b0, man_done = 1'b0, model_en = 1'b0;
    int              model_cnt = 0, model_delay = 5;

    int   cyc = 0, n_tests = 0, n_fail = 0, base = 0;
    ev_t  exp_q[$], obs_q[$];
    ev_t  e, o;
    logic [2:0] prev_grant = 3'd0;

    assign tmr_done_i = model_done | man_done;

    timer_arbiter #(.NUM_REQ(3), .CNT_W(CW), .WD_MARGIN(16)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .req_count_i(req_count_i),
        .grant_o(grant_o), .done_o(done_o), .err_o(err_o), .busy_o(busy_o),
        .tmr_count_o(tmr_count_o), .tmr_start_o(tmr_start_o), .tmr_abort_o(tmr_abort_o),
        .tmr_done_i(tmr_done_i)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    // Timer model: pulses done model_delay cycles after the start strobe.
    always @(negedge clk_i) begin
        model_done = 1'b0;
        if (tmr_abort_o) begin
            model_cnt = 0;
        end else if (model_en && tmr_start_o) begin
            model_cnt = model_delay;
        end else if (model_cnt > 0) begin
            model_cnt  = model_cnt - 1;
            model_done = (model_cnt == 0);
        end
    end

    // Monitor: log every observable output event with the cycle it appeared in.
    always @(negedge clk_i) begin
        if (grant_o !== prev_grant) begin
            obs_q.push_back('{kind: K_GRANT, val: {29'd0, grant_o}, cyc: cyc});
            prev_grant = grant_o;
        end
        if (tmr_start_o) obs_q.push_back('{kind: K_START, val: {14'd0, tmr_count_o}, cyc: cyc});
        if (tmr_abort_o) obs_q.push_back('{kind: K_ABORT, val: 0, cyc: cyc});
        if (err_o)       obs_q.push_back('{kind: K_ERR, val: 0, cyc: cyc});
        if (done_o != 3'd0) obs_q.push_back('{kind: K_DONE, val: {29'd0, done_o}, cyc: cyc});
    end

    function automatic void push_exp(input int k, input int v, input int c);
        exp_q.push_back('{kind: k, val: v, cyc: c});
    endfunction

    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge clk_i);
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk_i);
        n_tests++;
        if ({grant_o, done_o, err_o, busy_o, tmr_start_o, tmr_abort_o, tmr_count_o} !== 28'd0) begin
            n_fail++;
            $display("FAIL reset_state: got %h, want 0",
                     {grant_o, done_o, err_o, busy_o, tmr_start_o, tmr_abort_o, tmr_count_o});
        end
        rst_ni = 1'b1;
        repeat (2) @(negedge clk_i);
    endtask

    task automatic test_round_robin;
        @(negedge clk_i);
        model_en = 1'b1;
        model_delay = 5;
        req_count_i = {18'd5, 18'd5, 18'd5};
        req_i = 3'b111;
        base = cyc + 1;
        for (int k = 0; k < 4; k++) begin
            push_exp(K_GRANT, (k == 1) ? 2 : ((k == 2) ? 4 : 1), base + 9*k);
            push_exp(K_START, 5, base + 9*k + 1);
            push_exp(K_GRANT, 0, base + 9*k + 8);
            push_exp(K_DONE, (k == 1) ? 2 : ((k == 2) ? 4 : 1), base + 9*k + 8);
        end
        wait_cyc(base + 35);
        req_i = 3'b000;
        wait_cyc(base + 40);
        model_en = 1'b0;
        while (exp_q.size() > 0 || obs_q.size() > 0) begin
            n_tests++;
            if (exp_q.size() == 0 || obs_q.size() == 0) begin
                n_fail++;
                $display("FAIL rr_events: %0d extra observed, %0d expected missing", obs_q.size(), exp_q.size());
                exp_q.delete(); obs_q.delete();
            end else begin
                e = exp_q.pop_front(); o = obs_q.pop_front();
                if (o.kind !== e.kind || o.val !== e.val || o.cyc !== e.cyc) begin
                    n_fail++;
                    $display("FAIL rr_event: got kind=%0d val=%0d cyc=%0d, want kind=%0d val=%0d cyc=%0d",
                             o.kind, o.val, o.cyc, e.kind, e.val, e.cyc);
                end
            end
        end
    endtask

    task automatic test_single;
        @(negedge clk_i);
        req_count_i = {18'd7, 18'd7, 18'd100};
        req_i = 3'b001;
        base = cyc + 1;
        push_exp(K_GRANT, 1, base);
        push_exp(K_START, 100, base + 1);
        push_exp(K_GRANT, 0, base + 103);
        push_exp(K_DONE, 1, base + 103);
        wait_cyc(base + 101);
        man_done = 1'b1;
        @(negedge clk_i);
        man_done = 1'b0;
        wait_cyc(base + 103);
        req_i = 3'b000;
        n_tests++;
        if (busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL single_busy: got %b, want 0", busy_o);
        end
        wait_cyc(base + 106);
        while (exp_q.size() > 0 || obs_q.size() > 0) begin
            n_tests++;
            if (exp_q.size() == 0 || obs_q.size() == 0) begin
                n_fail++;
                $display("FAIL single_events: %0d extra observed, %0d expected missing", obs_q.size(), exp_q.size());
                exp_q.delete(); obs_q.delete();
            end else begin
                e = exp_q.pop_front(); o = obs_q.pop_front();
                if (o.kind !== e.kind || o.val !== e.val || o.cyc !== e.cyc) begin
                    n_fail++;
                    $display("FAIL single_event: got kind=%0d val=%0d cyc=%0d, want kind=%0d val=%0d cyc=%0d",
                             o.kind, o.val, o.cyc, e.kind, e.val, e.cyc);
                end
            end
        end
    endtask

    task automatic test_zero_count;
        @(negedge clk_i);
        req_count_i = {18'd9, 18'd0, 18'd9};
        req_i = 3'b010;
        base = cyc + 1;
        push_exp(K_GRANT, 2, base);
        push_exp(K_GRANT, 0, base + 1);
        push_exp(K_DONE, 2, base + 1);
        wait_cyc(base);
        req_i = 3'b000;
        n_tests++;
        if (busy_o !== 1'b1) begin
            n_fail++;
            $display("FAIL zero_busy: got %b, want 1", busy_o);
        end
        wait_cyc(base + 4);
        while (exp_q.size() > 0 || obs_q.size() > 0) begin
            n_tests++;
            if (exp_q.size() == 0 || obs_q.size() == 0) begin
                n_fail++;
                $display("FAIL zero_events: %0d extra observed, %0d expected missing", obs_q.size(), exp_q.size());
                exp_q.delete(); obs_q.delete();
            end else begin
                e = exp_q.pop_front(); o = obs_q.pop_front();
                if (o.kind !== e.kind || o.val !== e.val || o.cyc !== e.cyc) begin
                    n_fail++;
                    $display("FAIL zero_event: got kind=%0d val=%0d cyc=%0d, want kind=%0d val=%0d cyc=%0d",
                             o.kind, o.val, o.cyc, e.kind, e.val, e.cyc);
                end
            end
        end
    endtask

    task automatic test_withdraw;
        @(negedge clk_i);
        req_count_i = {18'd0, 18'd0, 18'd1000};
        req_i = 3'b001;
        base = cyc + 1;
        push_exp(K_GRANT, 1, base);
        push_exp(K_START, 1000, base + 1);
        push_exp(K_GRANT, 0, base + 11);
        push_exp(K_ABORT, 0, base + 11);
        wait_cyc(base + 10);
        req_i = 3'b000;
        wait_cyc(base + 11);
        n_tests++;
        if (busy_o !== 1'b0 || err_o !== 1'b0) begin
            n_fail++;
            $display("FAIL withdraw_flags: got busy=%b err=%b, want 0 0", busy_o, err_o);
        end
        // Requester 0 is now behind 1 and 2; zero counts keep the follow-up grant short.
        wait_cyc(base + 12);
        req_count_i = {(3*CW){1'b0}};
        req_i = 3'b111;
        push_exp(K_GRANT, 2, base + 13);
        push_exp(K_GRANT, 0, base + 14);
        push_exp(K_DONE, 2, base + 14);
        wait_cyc(base + 13);
        req_i = 3'b000;
        wait_cyc(base + 17);
        while (exp_q.size() > 0 || obs_q.size() > 0) begin
            n_tests++;
            if (exp_q.size() == 0 || obs_q.size() == 0) begin
                n_fail++;
                $display("FAIL withdraw_events: %0d extra observed, %0d expected missing", obs_q.size(), exp_q.size());
                exp_q.delete(); obs_q.delete();
            end else begin
                e = exp_q.pop_front(); o = obs_q.pop_front();
                if (o.kind !== e.kind || o.val !== e.val || o.cyc !== e.cyc) begin
                    n_fail++;
                    $display("FAIL withdraw_event: got kind=%0d val=%0d cyc=%0d, want kind=%0d val=%0d cyc=%0d",
                             o.kind, o.val, o.cyc, e.kind, e.val, e.cyc);
                end
            end
        end
    endtask

    task automatic test_watchdog;
        @(negedge clk_i);
        req_count_i = {18'd0, 18'd0, 18'd20};
        req_i = 3'b001;
        base = cyc + 1;
        push_exp(K_GRANT, 1, base);
        push_exp(K_START, 20, base + 1);
        push_exp(K_ABORT, 0, base + 38);
        push_exp(K_ERR, 0, base + 38);
        push_exp(K_GRANT, 0, base + 39);
        push_exp(K_DONE, 1, base + 39);
        wait_cyc(base + 39);
        req_i = 3'b000;
        // Withdrawal and tmr_done on the same edge: abort wins, no done.
        wait_cyc(base + 41);
        req_i = 3'b001;
        push_exp(K_GRANT, 1, base + 42);
        push_exp(K_START, 20, base + 43);
        push_exp(K_GRANT, 0, base + 48);
        push_exp(K_ABORT, 0, base + 48);
        wait_cyc(base + 47);
        req_i = 3'b000;
        man_done = 1'b1;
        @(negedge clk_i);
        man_done = 1'b0;
        wait_cyc(base + 52);
        while (exp_q.size() > 0 || obs_q.size() > 0) begin
            n_tests++;
            if (exp_q.size() == 0 || obs_q.size() == 0) begin
                n_fail++;
                $display("FAIL wd_events: %0d extra observed, %0d expected missing", obs_q.size(), exp_q.size());
                exp_q.delete(); obs_q.delete();
            end else begin
                e = exp_q.pop_front(); o = obs_q.pop_front();
                if (o.kind !== e.kind || o.val !== e.val || o.cyc !== e.cyc) begin
                    n_fail++;
                    $display("FAIL wd_event: got kind=%0d val=%0d cyc=%0d, want kind=%0d val=%0d cyc=%0d",
                             o.kind, o.val, o.cyc, e.kind, e.val, e.cyc);
                end
            end
        end
    endtask

    task automatic test_reset_mid;
        @(negedge clk_i);
        req_count_i = {18'd0, 18'd50, 18'd0};
        req_i = 3'b010;
        base = cyc + 1;
        push_exp(K_GRANT, 2, base);
        push_exp(K_START, 50, base + 1);
        push_exp(K_GRANT, 0, -1);
        wait_cyc(base + 5);
        #2 rst_ni = 1'b0;
        #1;
        n_tests++;
        if ({grant_o, done_o, err_o, busy_o, tmr_start_o, tmr_abort_o, tmr_count_o} !== 28'd0) begin
            n_fail++;
            $display("FAIL reset_mid_state: got %h, want 0",
                     {grant_o, done_o, err_o, busy_o, tmr_start_o, tmr_abort_o, tmr_count_o});
        end
        req_i = 3'b000;
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        // With ptr back at 0, requester 0 must win over requester 2.
        @(negedge clk_i);
        req_count_i = {(3*CW){1'b0}};
        req_i = 3'b101;
        base = cyc + 1;
        push_exp(K_GRANT, 1, base);
        push_exp(K_GRANT, 0, base + 1);
        push_exp(K_DONE, 1, base + 1);
        wait_cyc(base);
        req_i = 3'b000;
        wait_cyc(base + 4);
        while (exp_q.size() > 0 || obs_q.size() > 0) begin
            n_tests++;
            if (exp_q.size() == 0 || obs_q.size() == 0) begin
                n_fail++;
                $display("FAIL rstmid_events: %0d extra observed, %0d expected missing", obs_q.size(), exp_q.size());
                exp_q.delete(); obs_q.delete();
            end else begin
                e = exp_q.pop_front(); o = obs_q.pop_front();
                if (o.kind !== e.kind || o.val !== e.val || (e.cyc >= 0 && o.cyc !== e.cyc)) begin
                    n_fail++;
                    $display("FAIL rstmid_event: got kind=%0d val=%0d cyc=%0d, want kind=%0d val=%0d cyc=%0d",
                             o.kind, o.val, o.cyc, e.kind, e.val, e.cyc);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_single();
        test_zero_count();
        test_withdraw();
        test_watchdog();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
